// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: state encoding,
// BCD digit geometry and the default centisecond prescale.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      LAP_HOLD = 2'd2,
      PAUSE    = 2'd3
   } state_t;

   localparam int BCD_W        = 4;
   localparam int NUM_DIGITS   = 6;
   localparam int DIGIT_MAX    = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int SEC_TENS_IDX = 3;
   localparam int TICK_DIV_DEF = 1_000_000;

   // Digit 0 is cs_ones, digit 5 is min_tens.
   typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_time_t;

   function automatic logic [BCD_W-1:0] digit_limit(input int idx);
      return (idx == SEC_TENS_IDX) ? BCD_W'(SEC_TENS_MAX) : BCD_W'(DIGIT_MAX);
   endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Enable-gated centisecond prescaler; holds while disabled so a resume
// finishes the partial centisecond.
module tick_gen
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear FSM sequencing a BCD MM:SS.CC counter, with a lap
// freeze register and a registered display mux.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_stop,
   input  logic             lap,
   input  logic             clear,
   output logic [BCD_W-1:0] cs_ones,
   output logic [BCD_W-1:0] cs_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             running,
   output logic             lap_active,
   output logic             overflow
);

   state_t    state;
   bcd_time_t cnt, cnt_inc, cnt_adv, lap_reg, disp;
   logic      tick, wrap, counting, presc_clr;

   assign counting  = (state == RUN) || (state == LAP_HOLD);
   // Zero the prescaler in the same edge that a clear leaves PAUSE.
   assign presc_clr = (state == IDLE) || ((state == PAUSE) && clear);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (counting),
      .clr     (presc_clr),
      .tick    (tick)
   );

   // Ripple carry through the digits; a carry out of min_tens means wrap.
   always_comb begin
      cnt_inc = cnt;
      wrap    = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wrap) begin
            if (cnt[i] == digit_limit(i)) begin
               cnt_inc[i] = '0;
            end else begin
               cnt_inc[i] = cnt[i] + 1'b1;
               wrap       = 1'b0;
            end
         end
      end
   end

   assign cnt_adv = tick ? cnt_inc : cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         lap_reg    <= '0;
         disp       <= '0;
         overflow   <= 1'b0;
         running    <= 1'b0;
         lap_active <= 1'b0;
      end else begin
         cnt  <= cnt_adv;
         disp <= cnt_adv;
         if (tick && wrap)
            overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (start_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (start_stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (lap) begin
                  state      <= LAP_HOLD;
                  lap_active <= 1'b1;
                  lap_reg    <= cnt;
                  disp       <= cnt;
               end
            end
            LAP_HOLD: begin
               if (start_stop) begin
                  state      <= PAUSE;
                  running    <= 1'b0;
                  lap_active <= 1'b0;
               end else if (lap) begin
                  state      <= RUN;
                  lap_active <= 1'b0;
               end else begin
                  disp <= lap_reg;
               end
            end
            PAUSE: begin
               if (clear) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  disp     <= '0;
                  overflow <= 1'b0;
               end else if (start_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cs_ones  = disp[0];
   assign cs_tens  = disp[1];
   assign sec_ones = disp[2];
   assign sec_tens = disp[3];
   assign min_ones = disp[4];
   assign min_tens = disp[5];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV=4; expectations are queued by
// cycle number and checked by an independent negedge monitor.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
   logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
   logic       running, lap_active, overflow;

   stopwatch_ctrl #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .cs_ones    (cs_ones),
      .cs_tens    (cs_tens),
      .sec_ones   (sec_ones),
      .sec_tens   (sec_tens),
      .min_ones   (min_ones),
      .min_tens   (min_tens),
      .running    (running),
      .lap_active (lap_active),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [23:0] disp;
      logic        run;
      logic        lapa;
      logic        ovf;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor: compare every expectation due in the current cycle.
   exp_t        e;
   logic [23:0] got;
   always @(negedge clk) begin
      got = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         vectors++;
         if (e.cyc < cyc) begin
            miscompares++;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.tag, e.cyc, cyc);
         end else if (got !== e.disp || running !== e.run || lap_active !== e.lapa || overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL %s @%0d: got disp=%h run=%b lap=%b ovf=%b, want disp=%h run=%b lap=%b ovf=%b",
                     e.tag, cyc, got, running, lap_active, overflow, e.disp, e.run, e.lapa, e.ovf);
         end
      end
   end

   task automatic ex(input int c, input logic [23:0] d, input logic r, input logic l,
                     input logic o, input string tag);
      exp_t x;
      x.cyc = c; x.disp = d; x.run = r; x.lapa = l; x.ovf = o; x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic pulse(input logic ss, input logic lp, input logic cl);
      start_stop = ss; lap = lp; clear = cl;
      step(1);
      start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      ex(cyc, 24'h000000, 1'b0, 1'b0, 1'b0, "reset");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n, m, f, s;

   initial begin
      step(1);

      // Start latency, first ticks, second and minute carries
      do_reset();
      n = cyc;
      ex(n + 1,     24'h000000, 1, 0, 0, "start_running");
      ex(n + 4,     24'h000000, 1, 0, 0, "pre_first_tick");
      ex(n + 5,     24'h000001, 1, 0, 0, "first_tick");
      ex(n + 9,     24'h000002, 1, 0, 0, "second_tick");
      ex(n + 401,   24'h000100, 1, 0, 0, "one_second");
      ex(n + 24000, 24'h005999, 1, 0, 0, "00_59_99");
      ex(n + 24001, 24'h010000, 1, 0, 0, "minute_carry");
      pulse(1, 0, 0);
      wait_until(n + 24003);

      // Lap freeze and release
      do_reset();
      n = cyc;
      pulse(1, 0, 0);
      ex(n + 151, 24'h000037, 1, 1, 0, "lap_capture");
      ex(n + 170, 24'h000037, 1, 1, 0, "lap_frozen");
      ex(n + 191, 24'h000047, 1, 0, 0, "lap_release");
      wait_until(n + 150);
      pulse(0, 1, 0);
      wait_until(n + 190);
      pulse(0, 1, 0);
      wait_until(n + 193);

      // Pause with partial centisecond, resume, clear ignored in RUN / honoured in PAUSE
      do_reset();
      n = cyc;
      m = n + 12;
      pulse(1, 0, 0);
      ex(n + 5, 24'h000001, 1, 0, 0, "pre_pause");
      ex(n + 7, 24'h000001, 0, 0, 0, "paused");
      ex(m + 1, 24'h000001, 1, 0, 0, "resumed");
      ex(m + 2, 24'h000001, 1, 0, 0, "resume_no_tick_yet");
      ex(m + 3, 24'h000002, 1, 0, 0, "resume_tick");
      ex(m + 5, 24'h000002, 1, 0, 0, "clear_in_run_ignored");
      ex(m + 7, 24'h000003, 1, 0, 0, "still_counting");
      ex(m + 9, 24'h000003, 0, 0, 0, "paused_again");
      ex(m + 10, 24'h000003, 0, 0, 0, "lap_in_pause_ignored");
      ex(m + 11, 24'h000000, 0, 0, 0, "clear_in_pause");
      ex(m + 12, 24'h000000, 0, 0, 0, "lap_in_idle_ignored");
      wait_until(n + 6);
      pulse(1, 0, 0);
      wait_until(m);
      pulse(1, 0, 0);
      wait_until(m + 4);
      pulse(0, 0, 1);
      wait_until(m + 8);
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      pulse(0, 0, 1);
      pulse(0, 1, 0);
      wait_until(m + 13);

      // Final tick on pause, preload to 99:59.99, wrap and overflow
      do_reset();
      n = cyc;
      pulse(1, 0, 0);
      ex(n + 5, 24'h000001, 0, 0, 0, "pause_on_tick_counts");
      wait_until(n + 4);
      pulse(1, 0, 0);
      wait_until(n + 8);
      f = cyc;
      m = f + 3;
      ex(f + 1, 24'h995999, 0, 0, 0, "preload");
      ex(m + 1, 24'h995999, 1, 0, 0, "preload_resumed");
      ex(m + 4, 24'h995999, 1, 0, 0, "before_wrap");
      ex(m + 5, 24'h000000, 1, 0, 1, "wrap_overflow");
      ex(m + 9, 24'h000001, 1, 0, 1, "overflow_sticky");
      ex(m + 11, 24'h000001, 0, 0, 1, "overflow_in_pause");
      ex(m + 13, 24'h000000, 0, 0, 0, "clear_overflow");
      force dut.cnt = 24'h995999;
      step(1);
      release dut.cnt;
      wait_until(m);
      pulse(1, 0, 0);
      wait_until(m + 10);
      pulse(1, 0, 0);
      wait_until(m + 12);
      pulse(0, 0, 1);
      wait_until(m + 14);

      // Simultaneous pulses and reset in LAP_HOLD
      do_reset();
      n = cyc;
      s = n + 8;
      pulse(1, 0, 0);
      ex(n + 3, 24'h000000, 0, 0, 0, "paused_early");
      ex(n + 6, 24'h000000, 0, 0, 0, "clear_beats_start");
      ex(n + 7, 24'h000000, 0, 0, 0, "idle_stays_stopped");
      ex(s + 1, 24'h000000, 1, 0, 0, "restart");
      ex(s + 4, 24'h000000, 0, 0, 0, "start_beats_lap");
      ex(s + 8, 24'h000001, 1, 0, 0, "resume_tick_p3");
      ex(s + 9, 24'h000001, 1, 1, 0, "lap_hold");
      ex(s + 10, 24'h000001, 1, 1, 0, "lap_hold_2");
      ex(s + 11, 24'h000000, 0, 0, 0, "reset_in_lap_hold");
      wait_until(n + 2);
      pulse(1, 0, 0);
      wait_until(n + 5);
      pulse(1, 0, 1);
      wait_until(s);
      pulse(1, 0, 0);
      wait_until(s + 3);
      pulse(1, 1, 0);
      wait_until(s + 6);
      pulse(1, 0, 0);
      wait_until(s + 8);
      pulse(0, 1, 0);
      wait_until(s + 10);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(3);

      if (sb.size() != 0) begin
         miscompares += sb.size();
         $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/lap/clear controller for the stopwatch datapath. It gates an internal 100 Hz tick prescaler and sequences a BCD time counter (MM:SS.CC, 00:00.00 to 99:59.99). It also owns the lap-freeze display register. It sits between the debounced, single-cycle button pulses and the 7-segment display multiplexer, and it replaces free-running use of the slow-clock divider with an enable-gated tick.

## Interface
Parameters:
- TICK_DIV, default 1_000_000: clk cycles per centisecond tick (100 MHz -> 100 Hz); legal range ≥ 2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- lap  in  1  single-cycle pulse; freezes or releases the display while counting.
- clear  in  1  single-cycle pulse; zeroes the time while paused.
- cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens  out  4 each  displayed BCD digits.
- running  out  1  high in RUN and LAP_HOLD.
- lap_active  out  1  high in LAP_HOLD.
- overflow  out  1  sticky flag: the counter wrapped past 99:59.99.

## Operation
- States:
  - IDLE: stopped, time zero.
  - RUN: counting, live display.
  - LAP_HOLD: counting, frozen display.
  - PAUSE: stopped, live display.
- Transitions, evaluated once per cycle:
  - IDLE: start_stop -> RUN. lap and clear ignored.
  - RUN: start_stop -> PAUSE; otherwise lap -> LAP_HOLD, capturing the current (pre-increment) counter value into the lap register. clear ignored.
  - LAP_HOLD: start_stop -> PAUSE, display returns live; otherwise lap -> RUN, display live. clear ignored.
  - PAUSE: clear -> IDLE, zeroing counter, prescaler and overflow; otherwise start_stop -> RUN. lap ignored.
- Simultaneous pulses: priority is clear > start_stop > lap. Lower-priority pulses in the same cycle are discarded, not queued.
- Prescaler:
  - Counts only in RUN/LAP_HOLD.
  - Holds its value in PAUSE, so resume continues the partial centisecond.
  - Forced to 0 in IDLE.
  - Asserts tick when count == TICK_DIV-1 while counting, then wraps to 0.
- Time counter advances by one centisecond on each tick, with cascaded BCD carry:
  - cs_ones 9->0 carries into cs_tens.
  - cs_tens 9->0 carries into sec_ones.
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - min_tens 9->0 wraps the whole counter to 00:00.00 and sets overflow.
- BCD digits never leave their range (0-9, or 0-5 for sec_tens).
- A tick and a state-changing pulse in the same cycle: the tick is applied. RUN->PAUSE still counts that final tick.
- Display mux: lap register in LAP_HOLD, counter otherwise.

## Timing
- Reset (reset_n low at a posedge): state IDLE, all digits 0, prescaler 0, lap register 0, running=0, lap_active=0, overflow=0.
  - Reset takes effect from any state, including mid-count or in LAP_HOLD.
  - Reset has priority over every pulse.
- All outputs are registered; a pulse at cycle N changes state and outputs at N+1.
- From IDLE, start_stop at cycle N:
  - running=1 at N+1.
  - Prescaler = 0 at N+1.
  - First tick at cycle N+TICK_DIV.
  - cs_ones=1 visible at N+TICK_DIV+1.
- Steady-state tick period: exactly TICK_DIV cycles in RUN/LAP_HOLD.
- Pausing at prescaler value P, then resuming at cycle M: next tick at M+TICK_DIV-P.
- Lap capture: the value shown at N+1 equals the counter value at cycle N.
- Overflow rises the cycle after the wrapping tick. It stays high until clear in PAUSE, or reset.

## Structure
- Shared package stopwatch_pkg:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, LAP_HOLD=2'd2, PAUSE=2'd3);
  - BCD digit width (4);
  - digit limits (9, 5);
  - default TICK_DIV.
- Sub-module tick_gen:
  - parameter TICK_DIV;
  - inputs clk, reset_n, en, clr; output tick;
  - counter width $clog2(TICK_DIV).
- stopwatch_ctrl holds the FSM, BCD cascade, lap register and output mux.

## Test plan
Benches run with TICK_DIV=4.
1. Reset, then start_stop at cycle 0 -> running=1 at cycle 1; cs_ones=1 at cycle 5; cs_ones=2 at cycle 9.
2. Run 400 cycles (100 ticks) -> display 00:01.00. Run to 5999 total ticks -> 00:59.99; next tick -> 01:00.00.
3. lap at 00:00.37 -> display stays 00:00.37 with lap_active=1 while counting continues. Second lap after 10 more ticks -> display 00:00.47, lap_active=0.
4. Pause at prescaler=2, then resume -> next tick 2 cycles after resume. clear while RUN -> ignored. clear in PAUSE -> 00:00.00, state IDLE.
5. Preload to 99:59.99 (run 599999 ticks, or force) -> next tick gives 00:00.00 and overflow=1. clear in PAUSE -> overflow=0.
6. clear+start_stop in the same cycle in PAUSE -> IDLE. start_stop+lap in RUN -> PAUSE, lap_active=0. reset_n low in LAP_HOLD -> all outputs 0 the next cycle.
